ssd_scan_driver: RTL and testbench
==================================

Name: ssd_scan_driver

Overview:
Parametrised multiplexed seven-segment driver, successor to the fixed 4-digit display path. Scans NUM_DIGITS common-anode digits from a packed nibble bus. Adds per-digit decimal-point, blank and blink masks, 16-level PWM brightness, inter-digit dead time and frame-synchronous double buffering. Sits between the clock/alarm datapath (already BCD-converted) and the board pins.

Parameters:
NUM_DIGITS, 4, digits scanned; legal 1..8.
SCAN_DIV, 5000, clk cycles per digit slot; legal >= 16.
BLINK_FRAMES, 50, full frames per blink half-period; legal >= 1.

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  asynchronous reset, active-low
data  in  4*NUM_DIGITS  hex nibble per digit; nibble i drives digit i, digit 0 rightmost
dp_mask  in  NUM_DIGITS  1 = decimal point lit on digit i
blank_mask  in  NUM_DIGITS  1 = digit i dark
blink_mask  in  NUM_DIGITS  1 = digit i blinks
brightness  in  4  duty level; 15 = full, 0 = 1/16
frame_start  out  1  one-cycle pulse when shadow registers load
cathode  out  8  active-low; [0]=a .. [6]=g, [7]=dp
anode  out  NUM_DIGITS  active-low one-hot digit enable

Behaviour:
- Reset (rst=0, asynchronous): prescaler=0, digit index=0, pwm counter=0, blink frame counter=0, blink phase=0, shadow data/dp/blank/blink=0, frame_start=0, anode all 1, cathode 8'hFF. Outputs stay dark until the first load.
- Prescaler: $clog2(SCAN_DIV) bits, counts 0..SCAN_DIV-1 then wraps to 0; tick = (prescaler == SCAN_DIV-1).
- Digit index: $clog2(NUM_DIGITS) bits (min 1), increments on tick, wraps NUM_DIGITS-1 -> 0.
- Frame load: on a tick with index == NUM_DIGITS-1, data/dp_mask/blank_mask/blink_mask are captured into shadow registers and frame_start pulses in the following cycle. Input changes mid-frame never appear until the next frame. First load occurs at the end of the first frame after reset.
- Blink: frame counter increments on each frame load; at BLINK_FRAMES-1 it wraps to 0 and blink phase toggles. Digit blanked when shadow blink bit=1 and phase=1.
- PWM: free-running 4-bit counter; digit lit only while pwm counter <= brightness. brightness sampled live (not shadowed).
- Dead time: anode all 1 while prescaler == 0 (first cycle of every slot) to suppress ghosting.
- Output stage: anode and cathode registered; one cycle after prescaler/index/pwm state. anode[idx]=0 only when not dead time, not blank, not blink-dark and PWM-on; otherwise all anodes 1. cathode carries the glyph of shadow nibble idx regardless of anode state.
- Font: standard hex 0-9, A, b, C, d, E, F; dp bit = ~shadow dp[idx].
- NUM_DIGITS=1: index stays 0; every tick is a frame load.
- Reset mid-scan: immediate return to reset values; scan restarts at digit 0.

Optional Feature:
Macro SSD_LEADING_ZERO_BLANK_EN. Defined: every digit above the most significant nonzero shadow nibble is treated as blanked; digit 0 is never suppressed (value 0 shows "0"); dp on a suppressed digit is also dark. Not defined: all digits displayed per masks only; the logic is absent.

Test Plan:
- Reset held, then released, NUM_DIGITS=4, SCAN_DIV=16 -> anode=4'hF, cathode=8'hFF until first frame_start; frame_start at cycle 64 after release.
- data=16'h1234, brightness=15, masks 0 -> in slot for digit 0 anode=4'b1110, cathode=8'b1001_1001 ("4"); digit 3 anode=4'b0111, cathode=8'b1111_1001 ("1"); anodes dark on the first cycle of each slot.
- data changed 16'h1234->16'hABCD mid-frame -> cathodes keep "1234" glyphs until the next frame_start, then "AbCd".
- brightness=0 -> active anode low 1 of every 16 cycles; brightness=7 -> 8 of 16 (excluding dead-time cycle).
- BLINK_FRAMES=2, blink_mask=4'b0001, dp_mask=4'b0010 -> digit 0 dark for 2 frames, lit for 2; digit 1 cathode[7]=0 always.
- With SSD_LEADING_ZERO_BLANK_EN, data=16'h0042 -> digits 3,2 anode never low, digits 1,0 show "4","2"; data=16'h0000 -> only digit 0 shows "0".

Source files
------------

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: multiplexed seven-segment scan driver for NUM_DIGITS
// common-anode digits. It scans one digit per SCAN_DIV-cycle slot and adds
// per-digit decimal point, blank and blink masks, 16-level PWM brightness and
// a one-cycle dead time at the start of every slot. Inputs are double-buffered
// so that they take effect only at frame boundaries.
//
// Optional feature: define SSD_LEADING_ZERO_BLANK_EN to suppress every digit
// above the most significant nonzero shadow nibble. Digit 0 is never
// suppressed, and a suppressed digit also has its decimal point dark.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active-low
//   data         packed hex nibbles; nibble i drives digit i (digit 0 rightmost)
//   dp_mask      1 = decimal point lit on digit i
//   blank_mask   1 = digit i dark
//   blink_mask   1 = digit i blinks
//   brightness   PWM duty level, sampled live (15 = full, 0 = 1/16)
//   frame_start  one-cycle pulse in the cycle after the shadow registers load
//   cathode      active-low segments, [0]=a .. [6]=g, [7]=dp
//   anode        active-low one-hot digit enable
module ssd_scan_driver #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 5000,
  parameter int unsigned BLINK_FRAMES = 50
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [3:0]              brightness,
  output logic                    frame_start,
  output logic [7:0]              cathode,
  output logic [NUM_DIGITS-1:0]   anode
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned DW = 4 * NUM_DIGITS;

  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);

  // ST_DARK holds the outputs dark until the first frame load
  typedef enum logic {
    ST_DARK = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [3:0]            pwm;
  logic [BW-1:0]         blink_cnt;
  logic                  blink_phase;

  logic [DW-1:0]         sh_data;
  logic [NUM_DIGITS-1:0] sh_dp;
  logic [NUM_DIGITS-1:0] sh_blank;
  logic [NUM_DIGITS-1:0] sh_blink;

  logic                  tick;
  logic                  load;
  logic                  dead;
  logic                  lit;
  logic [NUM_DIGITS-1:0] lz_sup;
  logic [NUM_DIGITS-1:0] sel;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_dark;
  logic                  cur_blink;

  // Hex font, active-low, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b100_0000;
      4'h1:    s = 7'b111_1001;
      4'h2:    s = 7'b010_0100;
      4'h3:    s = 7'b011_0000;
      4'h4:    s = 7'b001_1001;
      4'h5:    s = 7'b001_0010;
      4'h6:    s = 7'b000_0010;
      4'h7:    s = 7'b111_1000;
      4'h8:    s = 7'b000_0000;
      4'h9:    s = 7'b001_0000;
      4'hA:    s = 7'b000_1000;
      4'hB:    s = 7'b000_0011;
      4'hC:    s = 7'b100_0110;
      4'hD:    s = 7'b010_0001;
      4'hE:    s = 7'b000_0110;
      default: s = 7'b000_1110;
    endcase
    return s;
  endfunction

  assign tick = (presc == PRESC_MAX);
  assign load = tick && (idx == IDX_MAX);
  assign dead = (presc == '0);

  // Slot prescaler
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Digit index, advances once per slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= '0;
    end else if (tick) begin
      idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
    end
  end

  // Free-running PWM phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm <= 4'h0;
    end else begin
      pwm <= pwm + 4'h1;
    end
  end

  // Blink frame counter and phase, stepped on each frame load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (load) begin
      if (blink_cnt == BLINK_MAX) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  // Shadow registers, captured only at frame boundaries
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_data  <= '0;
      sh_dp    <= '0;
      sh_blank <= '0;
      sh_blink <= '0;
    end else if (load) begin
      sh_data  <= data;
      sh_dp    <= dp_mask;
      sh_blank <= blank_mask;
      sh_blink <= blink_mask;
    end
  end

  // Display-enable state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_DARK;
    end else begin
      state <= state_nxt;
    end
  end

  // Display-enable next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_DARK: if (load) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_DARK;
    endcase
  end

`ifdef SSD_LEADING_ZERO_BLANK_EN
  // A digit is suppressed when it and every digit above it hold zero
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz_sup     = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      zero_above = zero_above && (sh_data[4*i +: 4] == 4'h0);
      lz_sup[i]  = (i != 0) && zero_above;
    end
  end
`else
  assign lz_sup = '0;
`endif

  // Select the shadow state of the digit currently being scanned
  always_comb begin
    sel       = '0;
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_dark  = 1'b0;
    cur_blink = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx == IW'(i)) begin
        sel[i]    = 1'b1;
        cur_nib   = sh_data[4*i +: 4];
        cur_dp    = sh_dp[i] && !lz_sup[i];
        cur_dark  = sh_blank[i] || lz_sup[i];
        cur_blink = sh_blink[i];
      end
    end
  end

  assign lit = (state == ST_RUN) && !dead && !cur_dark &&
               !(cur_blink && blink_phase) && (pwm <= brightness);

  // Registered pin stage; the cathode follows the scanned glyph even when dark
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      anode       <= '1;
      cathode     <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      frame_start <= load;
      anode       <= lit ? ~sel : '1;
      cathode     <= (state == ST_RUN) ? {~cur_dp, seg7(cur_nib)} : 8'hFF;
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver: a 4-digit, SCAN_DIV=16, BLINK_FRAMES=2
// instance for scan, buffering, blink and dp behaviour, and a SCAN_DIV=17
// instance whose PWM phase walks through every slot for brightness counting.
module tb_ssd_scan_driver;

  logic        clk;
  logic        rst;
  logic [15:0] data;
  logic [3:0]  dp_mask;
  logic [3:0]  blank_mask;
  logic [3:0]  blink_mask;
  logic [3:0]  brightness;
  logic        frame_start;
  logic [7:0]  cathode;
  logic [3:0]  anode;

  logic [3:0]  brightness2;
  logic        frame_start2;
  logic [7:0]  cathode2;
  logic [3:0]  anode2;

  int n_checks;
  int n_pass;

  ssd_scan_driver #(
    .NUM_DIGITS  (4),
    .SCAN_DIV    (16),
    .BLINK_FRAMES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .dp_mask    (dp_mask),
    .blank_mask (blank_mask),
    .blink_mask (blink_mask),
    .brightness (brightness),
    .frame_start(frame_start),
    .cathode    (cathode),
    .anode      (anode)
  );

  ssd_scan_driver #(
    .NUM_DIGITS  (4),
    .SCAN_DIV    (17),
    .BLINK_FRAMES(50)
  ) dut_pwm (
    .clk        (clk),
    .rst        (rst),
    .data       (16'h1234),
    .dp_mask    (4'h0),
    .blank_mask (4'h0),
    .blink_mask (4'h0),
    .brightness (brightness2),
    .frame_start(frame_start2),
    .cathode    (cathode2),
    .anode      (anode2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bounded wait for a frame_start pulse on the selected instance
  task automatic wait_fs(input int which, input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      step(1);
      if (((which == 0) ? frame_start : frame_start2) === 1'b1) seen = 1'b1;
    end
    chk(tag, 32'(seen), 1);
  endtask

  // Count lit samples over one whole frame of the PWM instance
  task automatic pwm_frame(input logic [3:0] lvl);
    int cnt_all;
    int cnt_d0;
    cnt_all = 0;
    cnt_d0  = 0;
    brightness2 = lvl;
    wait_fs(1, "pwm_fs");
    for (int k = 0; k < 68; k++) begin
      step(1);
      if (k == 0) chk("pwm_cath_d0", 32'(cathode2), 'h99);
      if (anode2 !== 4'hF) cnt_all++;
      if (anode2 === 4'b1110) cnt_d0++;
    end
    chk($sformatf("pwm_frame_b%0d", lvl), 32'(cnt_all), 32'(4 * (lvl + 1)));
    chk($sformatf("pwm_d0_b%0d", lvl), 32'(cnt_d0), 32'(lvl + 1));
  endtask

  initial begin
    int errs;
    int fs_at;
    logic [5:0] blink_dark;

    n_checks    = 0;
    n_pass      = 0;
    rst         = 1'b0;
    data        = 16'h1234;
    dp_mask     = 4'h0;
    blank_mask  = 4'h0;
    blink_mask  = 4'h0;
    brightness  = 4'hF;
    brightness2 = 4'hF;
    blink_dark  = 6'b011001;

    step(3);
    chk("rst_anode", 32'(anode), 'hF);
    chk("rst_cathode", 32'(cathode), 'hFF);
    chk("rst_fs", 32'(frame_start), 0);

    // Release 1 ns after an edge; the next edge is edge 1
    rst  = 1'b1;
    errs = 0;
    for (int k = 1; k <= 63; k++) begin
      step(1);
      if (anode !== 4'hF || cathode !== 8'hFF || frame_start !== 1'b0) errs++;
    end
    chk("dark_before_load", 32'(errs), 0);
    step(1);                                           // edge 64
    chk("fs_first_load", 32'(frame_start), 1);
    chk("fs_cycle_anode", 32'(anode), 'hF);
    chk("fs_cycle_cathode", 32'(cathode), 'hFF);

    step(1);                                           // edge 65
    chk("d0_dead_anode", 32'(anode), 'hF);
    chk("d0_dead_cath", 32'(cathode), 'h99);
    chk("fs_one_cycle", 32'(frame_start), 0);
    step(1);                                           // edge 66
    chk("d0_anode", 32'(anode), 'hE);
    chk("d0_cath_4", 32'(cathode), 'h99);

    data = 16'hABCD;
    step(15);                                          // edge 81
    chk("d1_dead_anode", 32'(anode), 'hF);
    chk("d1_cath_old_3", 32'(cathode), 'hB0);
    step(1);                                           // edge 82
    chk("d1_anode", 32'(anode), 'hD);
    step(32);                                          // edge 114
    chk("d3_anode", 32'(anode), 'h7);
    chk("d3_cath_old_1", 32'(cathode), 'hF9);
    step(14);                                          // edge 128
    chk("fs_second_load", 32'(frame_start), 1);
    chk("d3_cath_still_old", 32'(cathode), 'hF9);
    step(2);                                           // edge 130
    chk("d0_new_anode", 32'(anode), 'hE);
    chk("d0_cath_new_d", 32'(cathode), 'hA1);
    step(48);                                          // edge 178
    chk("d3_new_anode", 32'(anode), 'h7);
    chk("d3_cath_new_a", 32'(cathode), 'h88);

    // Masks captured at edge 192; phase sequence gives dark,lit,lit,dark,dark,lit
    blink_mask = 4'b0001;
    dp_mask    = 4'b0010;
    for (int f = 0; f < 6; f++) begin
      wait_fs(0, "fs_blink");
      step(2);
      chk($sformatf("blink_d0_f%0d", f), 32'(anode), blink_dark[f] ? 'hF : 'hE);
      chk($sformatf("blink_d0_cath_f%0d", f), 32'(cathode), 'hA1);
      step(16);
      chk($sformatf("dp_d1_anode_f%0d", f), 32'(anode), 'hD);
      chk($sformatf("dp_d1_cath_f%0d", f), 32'(cathode), 'h46);
    end

    // Leading-zero handling on 0042 with dp requested on digit 3
    blink_mask = 4'h0;
    dp_mask    = 4'b1000;
    data       = 16'h0042;
    wait_fs(0, "fs_lz");
    step(2);
    chk("lz_d0_anode", 32'(anode), 'hE);
    chk("lz_d0_cath_2", 32'(cathode), 'hA4);
    step(16);
    chk("lz_d1_anode", 32'(anode), 'hD);
    chk("lz_d1_cath_4", 32'(cathode), 'h99);
    step(16);
`ifdef SSD_LEADING_ZERO_BLANK_EN
    chk("lz_d2_anode", 32'(anode), 'hF);
`else
    chk("lz_d2_anode", 32'(anode), 'hB);
`endif
    chk("lz_d2_cath_0", 32'(cathode), 'hC0);
    step(16);
`ifdef SSD_LEADING_ZERO_BLANK_EN
    chk("lz_d3_anode", 32'(anode), 'hF);
    chk("lz_d3_cath_dp_dark", 32'(cathode), 'hC0);
`else
    chk("lz_d3_anode", 32'(anode), 'h7);
    chk("lz_d3_cath_dp_lit", 32'(cathode), 'h40);
`endif

    dp_mask = 4'h0;
    data    = 16'h0000;
    wait_fs(0, "fs_zero");
    step(2);
    chk("zero_d0_anode", 32'(anode), 'hE);
    chk("zero_d0_cath", 32'(cathode), 'hC0);
    step(16);
`ifdef SSD_LEADING_ZERO_BLANK_EN
    chk("zero_d1_anode", 32'(anode), 'hF);
`else
    chk("zero_d1_anode", 32'(anode), 'hD);
`endif
    chk("zero_d1_cath", 32'(cathode), 'hC0);

    // Brightness: each slot has 16 non-dead cycles covering every PWM phase
    pwm_frame(4'd0);
    pwm_frame(4'd7);
    pwm_frame(4'd15);

    // Asynchronous reset in the middle of a scan
    step(37);
    rst = 1'b0;
    #2;
    chk("midrst_anode", 32'(anode), 'hF);
    chk("midrst_cathode", 32'(cathode), 'hFF);
    chk("midrst_fs", 32'(frame_start), 0);
    step(2);
    rst   = 1'b1;
    fs_at = 0;
    for (int k = 1; k <= 100; k++) begin
      step(1);
      if (frame_start === 1'b1 && fs_at == 0) fs_at = k;
    end
    chk("fs_after_midrst", 32'(fs_at), 64);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
